// File: rtl/altair_pkg.sv
// Shared types and widths for the program loader and its byte FIFO.
package altair_pkg;

    localparam int unsigned MEM_ADDR_W = 16;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } loader_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } fifo_entry_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO holding pending {addr, data} memory writes.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Status flags, guarded push/pop and head-of-queue read
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        dout    = mem[rd_ptr];
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/prg_loader.sv
// Bridges the hps_io ioctl download stream to the main memory write port
// and pulses prg_load once a complete image has been written.
module prg_loader
    import altair_pkg::*;
#(
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter int unsigned           MEM_SIZE   = 65536,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR  = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [DATA_W-1:0]     ioctl_dout,
    output logic                  ioctl_wait,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    output logic                  prg_load,
    output logic                  load_active,
    output logic [16:0]           byte_count,
    output logic                  truncated,
    output logic                  overrun
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [24:0] MEM_LIMIT = 25'(MEM_SIZE);
    localparam logic [16:0] COUNT_MAX = '1;

    loader_state_t state;
    logic          dl_q;
    logic          dl_pend;
    logic          dl_rise;
    logic          in_range;
    logic          wr_load;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt_next;
    logic          wait_next;
    fifo_entry_t   push_entry;
    fifo_entry_t   head;

    // Accept/range decode, FIFO handshakes and next-cycle occupancy for ioctl_wait
    always_comb begin
        dl_rise         = ioctl_download & ~dl_q;
        in_range        = (ioctl_addr < MEM_LIMIT);
        wr_load         = (state == LOAD) & ioctl_wr;
        push            = wr_load & in_range & ~fifo_full;
        pop             = ~fifo_empty & mem_gnt;
        push_entry.addr = BASE_ADDR + ioctl_addr[MEM_ADDR_W-1:0];
        push_entry.data = ioctl_dout;
        cnt_next        = fifo_count + CW'(push) - CW'(pop);
        wait_next       = (cnt_next >= CW'(FIFO_DEPTH - 1));
    end

    // Memory port shows the FIFO head while it holds data, zero otherwise
    always_comb begin
        mem_req  = ~fifo_empty;
        mem_addr = fifo_empty ? '0 : head.addr;
        mem_data = fifo_empty ? '0 : head.data;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Load sequencing FSM with registered status outputs and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dl_q        <= 1'b0;
            dl_pend     <= 1'b0;
            ioctl_wait  <= 1'b0;
            prg_load    <= 1'b0;
            load_active <= 1'b0;
            byte_count  <= '0;
            truncated   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            dl_q     <= ioctl_download;
            prg_load <= 1'b0;
            if (pop && byte_count != COUNT_MAX) begin
                byte_count <= byte_count + 1'b1;
            end
            case (state)
                IDLE: begin
                    ioctl_wait <= 1'b0;
                    if (dl_rise || dl_pend) begin
                        state       <= LOAD;
                        dl_pend     <= 1'b0;
                        load_active <= 1'b1;
                        byte_count  <= '0;
                        truncated   <= 1'b0;
                        overrun     <= 1'b0;
                    end
                end
                LOAD: begin
                    ioctl_wait <= wait_next;
                    if (wr_load && !in_range) begin
                        truncated <= 1'b1;
                    end
                    if (wr_load && in_range && fifo_full) begin
                        overrun <= 1'b1;
                    end
                    // Level test: same as the falling edge in normal flow, and also
                    // exits when a latched restart finds download already low.
                    if (!ioctl_download) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dl_rise) begin
                        dl_pend <= 1'b1;
                    end
                    if (fifo_empty) begin
                        state       <= DONE;
                        prg_load    <= 1'b1;
                        load_active <= 1'b0;
                        ioctl_wait  <= 1'b0;
                    end else begin
                        ioctl_wait <= wait_next;
                    end
                end
                DONE: begin
                    if (dl_rise) begin
                        dl_pend <= 1'b1;
                    end
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: a default instance and one with a small
// memory window and a base address near the top of the address space.
module tb_prg_loader;

    localparam logic [15:0] BASE0 = 16'h0000;
    localparam logic [15:0] BASE1 = 16'hFFFE;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        mem_gnt;

    logic        ioctl_wait0, mem_req0, prg_load0, load_active0, truncated0, overrun0;
    logic [15:0] mem_addr0;
    logic [7:0]  mem_data0;
    logic [16:0] byte_count0;
    logic        ioctl_wait1, mem_req1, prg_load1, load_active1, truncated1, overrun1;
    logic [15:0] mem_addr1;
    logic [7:0]  mem_data1;
    logic [16:0] byte_count1;

    logic [23:0] q0[$];
    logic [23:0] q1[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          pulses0 = 0;
    int          pulses1 = 0;
    int          exp_pulses = 0;
    int          lat;

    always #5 clk = ~clk;

    prg_loader u_dut0 (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait0),
        .mem_req(mem_req0), .mem_gnt(mem_gnt), .mem_addr(mem_addr0), .mem_data(mem_data0),
        .prg_load(prg_load0), .load_active(load_active0), .byte_count(byte_count0),
        .truncated(truncated0), .overrun(overrun0)
    );

    prg_loader #(
        .FIFO_DEPTH (4),
        .MEM_SIZE   (4096),
        .BASE_ADDR  (BASE1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait1),
        .mem_req(mem_req1), .mem_gnt(mem_gnt), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .prg_load(prg_load1), .load_active(load_active1), .byte_count(byte_count1),
        .truncated(truncated1), .overrun(overrun1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [24:0] off, input logic [7:0] d, input bit acc0, input bit acc1);
        logic [15:0] a0;
        logic [15:0] a1;
        a0 = BASE0 + off[15:0];
        a1 = BASE1 + off[15:0];
        ioctl_wr   = 1'b1;
        ioctl_addr = off;
        ioctl_dout = d;
        if (acc0) q0.push_back({a0, d});
        if (acc1) q1.push_back({a1, d});
        tick(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick(1);
    endtask

    task automatic wait_pulse(input string tag, input int max_cyc, output int latency);
        bit found;
        found   = 1'b0;
        latency = 0;
        exp_pulses++;
        for (int i = 1; i <= max_cyc; i++) begin
            tick(1);
            if (prg_load0) begin
                found   = 1'b1;
                latency = i;
                break;
            end
        end
        check({tag, "_pulse"}, 32'(found), 32'd1);
    endtask

    // Write and pulse monitors, sampled away from the active edge
    always @(negedge clk) begin
        logic [23:0] e;
        if (!reset) begin
            if (mem_req0 && mem_gnt) begin
                check("wr0_expected", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    check("wr0", {8'h0, mem_addr0, mem_data0}, {8'h0, e});
                end
            end
            if (mem_req1 && mem_gnt) begin
                check("wr1_expected", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("wr1", {8'h0, mem_addr1, mem_data1}, {8'h0, e});
                end
            end
            if (prg_load0) begin
                pulses0++;
                check("pl0_fifo_empty", 32'(mem_req0), 32'd0);
            end
            if (prg_load1) begin
                pulses1++;
                check("pl1_fifo_empty", 32'(mem_req1), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mem_gnt        = 1'b1;
        tick(3);
        check("rst_req", 32'(mem_req0), 32'd0);
        check("rst_wait", 32'(ioctl_wait0), 32'd0);
        check("rst_pl", 32'(prg_load0), 32'd0);
        check("rst_active", 32'(load_active0), 32'd0);
        check("rst_count", 32'(byte_count0), 32'd0);
        check("rst_flags", {30'd0, truncated0, overrun0}, 32'd0);
        check("rst_addr_data", {8'h0, mem_addr0, mem_data0}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Basic load, continuous grant
        start_dl();
        check("basic_active", 32'(load_active0), 32'd1);
        send(25'd0, 8'h3E, 1, 1);
        send(25'd1, 8'hAA, 1, 1);
        send(25'd2, 8'hD3, 1, 1);
        send(25'd3, 8'hFF, 1, 1);
        ioctl_download = 1'b0;
        wait_pulse("basic", 6, lat);
        check("basic_latency_1to2", 32'(lat >= 1 && lat <= 2), 32'd1);
        check("basic_count", 32'(byte_count0), 32'd4);
        check("basic_flags", {30'd0, truncated0, overrun0}, 32'd0);
        check("basic_active_clr", 32'(load_active0), 32'd0);
        check("basic_all_written", 32'(q0.size()), 32'd0);
        tick(1);
        check("basic_pl_one_cycle", 32'(prg_load0), 32'd0);
        tick(2);

        // Backpressure with a source that reacts to wait one strobe late
        mem_gnt = 1'b0;
        start_dl();
        send(25'h10, 8'h01, 1, 1);
        send(25'h11, 8'h02, 1, 1);
        check("bp_wait_at2", 32'(ioctl_wait0), 32'd0);
        send(25'h12, 8'h03, 1, 1);
        check("bp_wait_at3", 32'(ioctl_wait0), 32'd1);
        send(25'h13, 8'h04, 1, 1);
        check("bp_wait_at4", 32'(ioctl_wait0), 32'd1);
        check("bp_overrun", 32'(overrun0), 32'd0);
        tick(2);
        check("bp_head_hold", {8'h0, mem_addr0, mem_data0}, 32'h00001001);
        mem_gnt = 1'b1;
        tick(1);
        check("bp_wait_cnt3", 32'(ioctl_wait0), 32'd1);
        tick(1);
        check("bp_wait_fall", 32'(ioctl_wait0), 32'd0);
        tick(2);
        check("bp_drained_4cyc", 32'(q0.size()), 32'd0);
        check("bp_req_low", 32'(mem_req0), 32'd0);
        ioctl_download = 1'b0;
        wait_pulse("bp", 6, lat);
        check("bp_count", 32'(byte_count0), 32'd4);
        tick(2);

        // Overrun: source ignores wait
        mem_gnt = 1'b0;
        start_dl();
        for (int i = 0; i < 6; i++) begin
            send(25'(32 + i), 8'(8'h40 + i), i < 4, i < 4);
        end
        check("ovr_flag", 32'(overrun0), 32'd1);
        check("ovr_trunc", 32'(truncated0), 32'd0);
        mem_gnt        = 1'b1;
        ioctl_download = 1'b0;
        wait_pulse("ovr", 12, lat);
        check("ovr_count", 32'(byte_count0), 32'd4);
        check("ovr_sticky", 32'(overrun0), 32'd1);
        tick(2);

        // Range: offset 4096 is outside the 4 KiB instance only
        start_dl();
        check("rng_ovr_cleared", 32'(overrun0), 32'd0);
        send(25'd4096, 8'h5A, 1, 0);
        check("rng_trunc1", 32'(truncated1), 32'd1);
        check("rng_noreq1", 32'(mem_req1), 32'd0);
        check("rng_trunc0", 32'(truncated0), 32'd0);
        check("rng_req0", 32'(mem_req0), 32'd1);
        ioctl_download = 1'b0;
        wait_pulse("rng", 6, lat);
        check("rng_count1", 32'(byte_count1), 32'd0);
        check("rng_count0", 32'(byte_count0), 32'd1);
        tick(2);

        // Address wrap past FFFF on the high-base instance
        start_dl();
        check("wrap_trunc_cleared", 32'(truncated1), 32'd0);
        send(25'd0, 8'h11, 1, 1);
        send(25'd1, 8'h22, 1, 1);
        send(25'd2, 8'h33, 1, 1);
        ioctl_download = 1'b0;
        wait_pulse("wrap", 6, lat);
        check("wrap_count1", 32'(byte_count1), 32'd3);
        check("wrap_all_written", 32'(q1.size()), 32'd0);
        tick(2);

        // Reset with bytes queued
        mem_gnt = 1'b0;
        start_dl();
        send(25'h50, 8'hA0, 1, 1);
        send(25'h51, 8'hA1, 1, 1);
        send(25'h52, 8'hA2, 1, 1);
        check("rml_req_before", 32'(mem_req0), 32'd1);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick(1);
        check("rml_req0", 32'(mem_req0), 32'd0);
        check("rml_req1", 32'(mem_req1), 32'd0);
        check("rml_active", 32'(load_active0), 32'd0);
        check("rml_wait", 32'(ioctl_wait0), 32'd0);
        q0.delete();
        q1.delete();
        reset   = 1'b0;
        mem_gnt = 1'b1;
        tick(4);
        check("rml_fifo_empty", 32'(mem_req0), 32'd0);
        check("rml_no_pulse", 32'(pulses0), 32'(exp_pulses));

        // Back-to-back: next download rises while draining
        mem_gnt = 1'b0;
        start_dl();
        send(25'h60, 8'hB0, 1, 1);
        send(25'h61, 8'hB1, 1, 1);
        ioctl_download = 1'b0;
        tick(2);
        ioctl_download = 1'b1;
        tick(1);
        mem_gnt = 1'b1;
        wait_pulse("b2b_first", 8, lat);
        check("b2b_first_count", 32'(byte_count0), 32'd2);
        tick(1);
        check("b2b_idle_inactive", 32'(load_active0), 32'd0);
        tick(1);
        check("b2b_second_active", 32'(load_active0), 32'd1);
        check("b2b_count_cleared", 32'(byte_count0), 32'd0);
        send(25'h70, 8'hC0, 1, 1);
        ioctl_download = 1'b0;
        wait_pulse("b2b_second", 6, lat);
        check("b2b_second_count", 32'(byte_count0), 32'd1);
        tick(3);

        check("pulses0_total", 32'(pulses0), 32'(exp_pulses));
        check("pulses1_total", 32'(pulses1), 32'(exp_pulses));
        check("q0_leftover", 32'(q0.size()), 32'd0);
        check("q1_leftover", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
